// File: rtl/prog_loader_pkg.sv
//==============================================================================
// Module   : prog_loader_pkg
// Purpose  : Shared types and default sizes for the run-time program loader.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package prog_loader_pkg;

  localparam int ADDR_W_DEF = 3;
  localparam int DATA_W_DEF = 8;
  localparam int NIBBLE_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HI    = 3'd1,
    ST_LO    = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/prog_ram.sv
//==============================================================================
// Module   : prog_ram
// Purpose  : DEPTH x DATA_W program RAM, synchronous write, asynchronous read.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module prog_ram
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  // No reset: contents must survive reset and successive loads.
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

`default_nettype wire

// File: rtl/prog_loader.sv
//==============================================================================
// Module   : prog_loader
// Purpose  : Pairs strobed nibbles into instruction words and writes them into
//            the program RAM while holding the CPU in reset.
//            Optional running checksum: define PROG_LOADER_CKSUM_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_load,
  input  logic [NIBBLE_W-1:0] i_nibble,
  input  logic                i_strobe,
  input  logic [ADDR_W-1:0]   i_raddr,
  output logic [DATA_W-1:0]   o_rdata,
  output logic                o_cpu_hold,
  output logic                o_busy,
  output logic                o_done,
  output logic [ADDR_W-1:0]   o_waddr,
  output logic                o_phase,
  output logic [DATA_W-1:0]   o_cksum
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_e                state_q, state_d;
  logic                  strobe_q;
  logic [ADDR_W-1:0]     waddr_q, waddr_d;
  logic [NIBBLE_W-1:0]   hi_q, hi_d;
  logic [NIBBLE_W-1:0]   lo_q, lo_d;
  logic                  w_strobe_edge;
  logic                  w_we;
  logic [DATA_W-1:0]     w_word;

  assign w_strobe_edge = i_strobe & ~strobe_q;
  assign w_word        = DATA_W'({hi_q, lo_q});
  assign w_we          = (state_q == ST_WRITE);

  // strobe_q resets high so a button held through reset yields no edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      strobe_q <= 1'b1;
      waddr_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      strobe_q <= i_strobe;
      waddr_q  <= waddr_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_load) begin
          state_d = ST_HI;
          waddr_d = '0;
          hi_d    = '0;
        end
      end
      ST_HI: begin
        if (w_strobe_edge) begin
          hi_d    = i_nibble;
          state_d = ST_LO;
        end
      end
      ST_LO: begin
        if (w_strobe_edge) begin
          lo_d    = i_nibble;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (waddr_q == LAST_ADDR) begin
          state_d = ST_DONE;
        end else begin
          waddr_d = waddr_q + ADDR_W'(1);
          state_d = ST_HI;
        end
      end
      ST_DONE: begin
        waddr_d = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    o_busy     = (state_q != ST_IDLE);
    o_cpu_hold = (state_q != ST_IDLE);
    o_phase    = (state_q == ST_LO);
    o_done     = (state_q == ST_DONE);
    o_waddr    = waddr_q;
  end

`ifdef PROG_LOADER_CKSUM_EN
  logic [DATA_W-1:0] cksum_q, cksum_d;

  always_comb begin
    cksum_d = cksum_q;
    if (state_q == ST_IDLE && i_load) begin
      cksum_d = '0;
    end else if (w_we) begin
      cksum_d = cksum_q + w_word;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cksum_q <= '0;
    end else begin
      cksum_q <= cksum_d;
    end
  end

  assign o_cksum = cksum_q;
`else
  assign o_cksum = '0;
`endif

  prog_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (waddr_q),
    .i_wdata (w_word),
    .i_raddr (i_raddr),
    .o_rdata (o_rdata)
  );

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
//==============================================================================
// Module   : tb_prog_loader
// Purpose  : Self-checking bench for prog_loader (table vectors + scoreboard).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              i_reset = 1'b1;
  logic              i_load = 1'b0;
  logic [3:0]        i_nibble = '0;
  logic              i_strobe = 1'b0;
  logic [ADDR_W-1:0] i_raddr = '0;
  logic [DATA_W-1:0] o_rdata;
  logic              o_cpu_hold, o_busy, o_done, o_phase;
  logic [ADDR_W-1:0] o_waddr;
  logic [DATA_W-1:0] o_cksum;

  always #5 clk = ~clk;

  prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_load(i_load), .i_nibble(i_nibble),
    .i_strobe(i_strobe), .i_raddr(i_raddr), .o_rdata(o_rdata),
    .o_cpu_hold(o_cpu_hold), .o_busy(o_busy), .o_done(o_done),
    .o_waddr(o_waddr), .o_phase(o_phase), .o_cksum(o_cksum)
  );

  typedef struct { logic [3:0] hi; logic [3:0] lo; logic [7:0] word; } vec_t;
  typedef struct { logic [2:0] addr; logic [7:0] word; } sb_t;

  vec_t       vecs [DEPTH];
  sb_t        sbq [$];
  logic [7:0] model_mem [DEPTH];
  logic [7:0] model_ck;
  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;

  always @(negedge clk) if (o_done === 1'b1) done_cnt++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk) i_reset = 1'b1;
    @(negedge clk);
    @(negedge clk) i_reset = 1'b0;
  endtask

  task automatic pulse_load();
    @(negedge clk) i_load = 1'b1;
    @(negedge clk) i_load = 1'b0;
    model_ck = 8'h00;
  endtask

  task automatic strobe_edge(input logic [3:0] nib);
    @(negedge clk);
    i_nibble = nib;
    i_strobe = 1'b1;
    @(negedge clk) i_strobe = 1'b0;
  endtask

  task automatic enter_word(input logic [2:0] addr, input logic [3:0] hi, input logic [3:0] lo);
    sb_t e;
    strobe_edge(hi);
    strobe_edge(lo);
    e.addr = addr;
    e.word = {hi, lo};
    sbq.push_back(e);
    model_mem[addr] = {hi, lo};
    model_ck = model_ck + {hi, lo};
  endtask

  task automatic drain();
    sb_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      @(negedge clk) i_raddr = e.addr;
      #1 chk("rdata_sb", 32'(o_rdata), 32'(e.word));
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (o_done !== 1'b1 && n < 5) begin
      tick();
      n++;
    end
    chk("done_seen", 32'(o_done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      vecs[i].hi   = 4'(i + 1);
      vecs[i].lo   = 4'(10 + i);
      vecs[i].word = {vecs[i].hi, vecs[i].lo};
    end
    model_ck = 8'h00;

    // Reset with strobe held high: no phantom edge afterwards.
    i_strobe = 1'b1;
    do_reset();
    chk("rst_busy",  32'(o_busy), 0);
    chk("rst_hold",  32'(o_cpu_hold), 0);
    chk("rst_phase", 32'(o_phase), 0);
    chk("rst_done",  32'(o_done), 0);
    chk("rst_waddr", 32'(o_waddr), 0);
    chk("rst_cksum", 32'(o_cksum), 0);
    pulse_load();
    chk("load_busy", 32'(o_busy), 1);
    chk("load_hold", 32'(o_cpu_hold), 1);
    tick(); tick(); tick();
    chk("held_strobe_phase", 32'(o_phase), 0);
    @(negedge clk) i_strobe = 1'b0;
    strobe_edge(4'h3);
    chk("after_hi_phase", 32'(o_phase), 1);
    strobe_edge(4'h7);
    chk("write_cycle_phase", 32'(o_phase), 0);
    chk("write_cycle_waddr", 32'(o_waddr), 0);
    tick();
    i_raddr = 3'd0;
    #1;
    chk("word37_rdata", 32'(o_rdata), 32'h37);
    chk("word37_waddr", 32'(o_waddr), 1);
    chk("word37_phase", 32'(o_phase), 0);
`ifdef PROG_LOADER_CKSUM_EN
    chk("word37_cksum", 32'(o_cksum), 32'h37);
`endif
    // i_load during HI must be ignored.
    pulse_load();
    chk("load_in_hi_waddr", 32'(o_waddr), 1);
    chk("load_in_hi_phase", 32'(o_phase), 0);
    chk("load_in_hi_busy",  32'(o_busy), 1);

    // Full load from the vector table.
    do_reset();
    pulse_load();
    done_cnt = 0;
    for (int i = 0; i < DEPTH; i++) begin
      enter_word(3'(i), vecs[i].hi, vecs[i].lo);
      chk("busy_mid_load", 32'(o_busy), 1);
    end
    chk("last_write_waddr", 32'(o_waddr), 7);
    wait_done();
    tick();
    chk("post_done_pulse", 32'(o_done), 0);
    chk("post_done_hold", 32'(o_cpu_hold), 0);
    chk("post_done_busy", 32'(o_busy), 0);
    chk("post_done_waddr", 32'(o_waddr), 0);
    chk("done_count", 32'(done_cnt), 1);
`ifdef PROG_LOADER_CKSUM_EN
    chk("full_cksum", 32'(o_cksum), 32'(model_ck));
`else
    chk("cksum_off", 32'(o_cksum), 0);
`endif
    drain();

    // Partial load, read-during-write on word 0, then reset mid-word.
    pulse_load();
    i_raddr = 3'd0;
    strobe_edge(4'h9);
    strobe_edge(4'h0);
    #1 chk("rdw_old_word", 32'(o_rdata), 32'(vecs[0].word));
    tick();
    #1 chk("rdw_new_word", 32'(o_rdata), 32'h90);
    begin
      sb_t e;
      e.addr = 3'd0;
      e.word = 8'h90;
      sbq.push_back(e);
      model_mem[0] = 8'h90;
    end
    for (int i = 1; i < 5; i++) enter_word(3'(i), 4'h9, 4'(i));
    strobe_edge(4'hC);
    chk("partial_phase", 32'(o_phase), 1);
    @(negedge clk) i_reset = 1'b1;
    @(negedge clk);
    chk("midreset_hold", 32'(o_cpu_hold), 0);
    chk("midreset_busy", 32'(o_busy), 0);
    i_reset = 1'b0;
    drain();

    // Strobe edges in IDLE must not touch anything.
    strobe_edge(4'h5);
    strobe_edge(4'h6);
    strobe_edge(4'h7);
    chk("idle_edges_busy", 32'(o_busy), 0);
    chk("idle_edges_waddr", 32'(o_waddr), 0);
    for (int a = 0; a < DEPTH; a++) begin
      @(negedge clk) i_raddr = 3'(a);
      #1 chk("ram_image", 32'(o_rdata), 32'(model_mem[a]));
    end

`ifdef PROG_LOADER_CKSUM_EN
    pulse_load();
    for (int i = 0; i < DEPTH; i++) enter_word(3'(i), 4'hF, 4'hF);
    wait_done();
    tick();
    chk("ff_cksum", 32'(o_cksum), 32'h0F8);
    pulse_load();
    chk("cksum_clear", 32'(o_cksum), 0);
    do_reset();
    drain();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
